ahb_sync_bridge: RTL

AHB_SYNC_BRIDGE -- requirements
Module: ahb_sync_bridge

---
 rtl/ahb_sync_bridge.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ahb_sync_bridge.sv
// Single-clock AHB-to-AHB bridge: upstream requests queue in a FIFO and are
// replayed downstream in order; writes can be posted, with a sticky error flag.
//
// state   | meaning
// U_IDLE  | no upstream data phase outstanding
// U_PUSH  | upstream data phase, waiting for a free FIFO slot
// U_WAIT  | read/non-posted write queued, waiting for downstream completion
// U_RESP  | OKAY completion cycle with registered read data
// U_ERR1  | first ERROR cycle (hreadyout low)
// U_ERR2  | second ERROR cycle (hreadyout high)
// M_IDLE  | downstream bus idle
// M_ADDR  | NONSEQ address phase for the FIFO head
// M_DATA  | data phase for the FIFO head, pop on completion
module ahb_sync_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int F_DEPTH    = 4,
  parameter int P_SIZE     = 3,
  parameter int POSTED_WR  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_sleep_req,
  output logic                  o_sleep_ack,
  input  logic                  i_wr_err_clr,
  output logic                  o_wr_err,
  output logic [P_SIZE-1:0]     o_fifo_level,
  input  logic                  i_hselx,
  input  logic [1:0]            i_htrans,
  input  logic [2:0]            i_hsize,
  input  logic                  i_hwrite,
  input  logic [ADDR_WIDTH-1:0] i_haddr,
  input  logic [DATA_WIDTH-1:0] i_hwdata,
  input  logic                  i_hready,
  output logic                  o_hreadyout,
  output logic                  o_hresp,
  output logic [DATA_WIDTH-1:0] o_hrdata,
  output logic [1:0]            o_htrans,
  output logic                  o_hwrite,
  output logic [2:0]            o_hsize,
  output logic [ADDR_WIDTH-1:0] o_haddr,
  output logic [DATA_WIDTH-1:0] o_hwdata,
  input  logic                  i_hready_sink,
  input  logic                  i_hresp_sink,
  input  logic [DATA_WIDTH-1:0] i_hrdata_sink
);
  localparam int  E_W    = 1 + 3 + ADDR_WIDTH + DATA_WIDTH;
  localparam bit  POSTED = (POSTED_WR != 0);

  typedef enum logic [2:0] {U_IDLE, U_PUSH, U_WAIT, U_RESP, U_ERR1, U_ERR2} u_state_t;
  typedef enum logic [1:0] {M_IDLE, M_ADDR, M_DATA} m_state_t;

  u_state_t u_state, u_next;
  m_state_t m_state, m_next;

  logic [E_W-1:0]        fifo_mem [F_DEPTH];
  logic [P_SIZE-1:0]     wr_ptr, rd_ptr, level;
  logic                  push, pop, full, accept, resp_done, wr_err_set, dp_posted;
  logic                  dp_write;
  logic [2:0]            dp_size;
  logic [ADDR_WIDTH-1:0] dp_addr;
  logic                  head_write;
  logic [2:0]            head_size;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;

  assign level        = wr_ptr - rd_ptr;
  assign full         = (level == P_SIZE'(F_DEPTH));
  assign o_fifo_level = level;
  assign {head_write, head_size, head_addr, head_data} = fifo_mem[rd_ptr[P_SIZE-2:0]];

  assign dp_posted  = dp_write & POSTED;
  assign accept     = i_hselx & (i_htrans inside {2'b10, 2'b11}) & i_hready & o_hreadyout
                      & ~i_sleep_req;
  assign push       = (u_state == U_PUSH) & ~full;
  assign pop        = (m_state == M_DATA) & i_hready_sink;
  // Only reads and non-posted writes owe the upstream master a response.
  assign resp_done  = pop & ~(head_write & POSTED);
  assign wr_err_set = pop & head_write & POSTED & i_hresp_sink;

  always_comb begin
    o_hreadyout = 1'b1;
    case (u_state)
      U_IDLE:         o_hreadyout = ~i_sleep_req;
      U_PUSH:         o_hreadyout = dp_posted & ~full;
      U_WAIT, U_ERR1: o_hreadyout = 1'b0;
      default:        o_hreadyout = 1'b1;
    endcase
  end

  assign o_hresp = (u_state == U_ERR1) | (u_state == U_ERR2);

  always_comb begin
    u_next = u_state;
    case (u_state)
      U_IDLE, U_RESP, U_ERR2: u_next = accept ? U_PUSH : U_IDLE;
      U_PUSH:
        if (!full) u_next = dp_posted ? (accept ? U_PUSH : U_IDLE) : U_WAIT;
      U_WAIT:
        if (resp_done) u_next = i_hresp_sink ? U_ERR1 : U_RESP;
      U_ERR1:  u_next = U_ERR2;
      default: u_next = U_IDLE;
    endcase
  end

  always_comb begin
    m_next   = m_state;
    o_htrans = 2'b00;
    o_hwrite = 1'b0;
    o_hsize  = '0;
    o_haddr  = '0;
    o_hwdata = '0;
    case (m_state)
      M_IDLE:
        if (level != '0 || push) m_next = M_ADDR;
      M_ADDR: begin
        o_htrans = 2'b10;
        o_hwrite = head_write;
        o_hsize  = head_size;
        o_haddr  = head_addr;
        if (i_hready_sink) m_next = M_DATA;
      end
      M_DATA: begin
        o_hwrite = head_write;
        o_hsize  = head_size;
        o_haddr  = head_addr;
        o_hwdata = head_data;
        // After this pop the FIFO holds level-1+push entries.
        if (i_hready_sink) m_next = (level > P_SIZE'(1) || push) ? M_ADDR : M_IDLE;
      end
      default: m_next = M_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr[P_SIZE-2:0]] <= {dp_write, dp_size, dp_addr, i_hwdata};
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      u_state     <= U_IDLE;
      m_state     <= M_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      dp_write    <= 1'b0;
      dp_size     <= '0;
      dp_addr     <= '0;
      o_hrdata    <= '0;
      o_wr_err    <= 1'b0;
      o_sleep_ack <= 1'b0;
    end else begin
      u_state <= u_next;
      m_state <= m_next;
      if (push) wr_ptr <= wr_ptr + P_SIZE'(1);
      if (pop)  rd_ptr <= rd_ptr + P_SIZE'(1);
      if (accept) begin
        dp_write <= i_hwrite;
        dp_size  <= i_hsize;
        dp_addr  <= i_haddr;
      end
      if (u_state == U_WAIT && resp_done) o_hrdata <= i_hrdata_sink;
      if (wr_err_set)        o_wr_err <= 1'b1;
      else if (i_wr_err_clr) o_wr_err <= 1'b0;
      o_sleep_ack <= i_sleep_req & (level == '0) & (m_state == M_IDLE) & (u_state == U_IDLE);
    end
  end
endmodule
